// File: rtl/branch_pkg.sv
// Shared types and constants for the branch sequencer and its comparator.
// Optional statistics counters in branch_seq are enabled with BRANCH_SEQ_STATS_EN.
package branch_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_OPS = 2'd1,
        EVAL     = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    // Two-code families (BEQ/BNE/BLEZ/BGTZ) ignore bit 0; only bits [3:1] are matched.
    localparam logic [3:0] BF_BLTZ = 4'b0010;
    localparam logic [3:0] BF_BGEZ = 4'b0011;
    localparam logic [3:0] BF_BEQ  = 4'b1000;
    localparam logic [3:0] BF_BNE  = 4'b1010;
    localparam logic [3:0] BF_BLEZ = 4'b1100;
    localparam logic [3:0] BF_BGTZ = 4'b1110;

    localparam logic [31:0] PC_STEP = 32'd4;

    function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [31:0] imm);
        return pc + PC_STEP + (imm << 2);
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator: signed compare of A/B selected by the
// branch function code; unknown codes resolve not-taken and raise illegal.
module branch_cmp
    import branch_pkg::*;
(
    input  logic [3:0]  code,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        res,
    output logic        illegal
);

    logic a_neg;
    logic a_zero;

    assign a_neg  = a[31];
    assign a_zero = (a == 32'd0);

    always_comb begin
        res     = 1'b0;
        illegal = 1'b0;
        if (code == BF_BLTZ) begin
            res = a_neg;
        end else if (code == BF_BGEZ) begin
            res = !a_neg;
        end else if (code[3:1] == BF_BEQ[3:1]) begin
            res = (a == b);
        end else if (code[3:1] == BF_BNE[3:1]) begin
            res = (a != b);
        end else if (code[3:1] == BF_BLEZ[3:1]) begin
            res = a_neg || a_zero;
        end else if (code[3:1] == BF_BGTZ[3:1]) begin
            res = !a_neg && !a_zero;
        end else begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/branch_seq.sv
// Branch sequencer: accepts a branch, waits for operands, evaluates it and issues a
// one-cycle redirect. Define BRANCH_SEQ_STATS_EN to add taken/not-taken counters.
module branch_seq
    import branch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        br_valid,
    input  logic [3:0]  br_bf,
    input  logic [31:0] br_src_a,
    input  logic [31:0] br_src_b,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_imm,
    input  logic        ops_ready,
    input  logic        kill,
    output logic        br_ready,
    output logic        stall,
    output logic        pc_src,
    output logic [31:0] pc_target,
`ifdef BRANCH_SEQ_STATS_EN
    output logic [15:0] stat_taken,
    output logic [15:0] stat_not_taken,
`endif
    output logic        flush,
    output logic        done,
    output logic        taken,
    output logic        bad_bf
);

    state_t      state_reg, state_next;
    logic [3:0]  bf_reg;
    logic [31:0] pc_reg, imm_reg, a_reg, b_reg;
    logic [31:0] pc_target_reg;
    logic        pc_src_reg, pc_src_next;
    logic        flush_reg, flush_next;
    logic        done_reg, done_next;
    logic        taken_reg, taken_next;
    logic        bad_reg, bad_next;
    logic        accept, ops_load;
    logic        cmp_res, cmp_illegal;

    branch_cmp u_cmp (
        .code    (bf_reg),
        .a       (a_reg),
        .b       (b_reg),
        .res     (cmp_res),
        .illegal (cmp_illegal)
    );

    // Pulses are computed from the current state and registered, so they appear
    // one cycle after EVAL/REDIRECT; this yields the 2/3-cycle branch latency.
    always_comb begin
        state_next  = state_reg;
        accept      = 1'b0;
        ops_load    = 1'b0;
        pc_src_next = 1'b0;
        flush_next  = 1'b0;
        done_next   = 1'b0;
        taken_next  = 1'b0;
        bad_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (br_valid) begin
                    accept     = 1'b1;
                    ops_load   = ops_ready;
                    state_next = ops_ready ? EVAL : WAIT_OPS;
                end
            end
            WAIT_OPS: begin
                if (ops_ready) begin
                    ops_load   = 1'b1;
                    state_next = EVAL;
                end
            end
            EVAL: begin
                if (cmp_res) begin
                    state_next = REDIRECT;
                end else begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                    bad_next   = cmp_illegal;
                end
            end
            REDIRECT: begin
                state_next  = IDLE;
                pc_src_next = 1'b1;
                flush_next  = 1'b1;
                done_next   = 1'b1;
                taken_next  = 1'b1;
            end
            default: state_next = IDLE;
        endcase
        if (kill) begin
            state_next  = IDLE;
            accept      = 1'b0;
            ops_load    = 1'b0;
            pc_src_next = 1'b0;
            flush_next  = 1'b0;
            done_next   = 1'b0;
            taken_next  = 1'b0;
            bad_next    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            bf_reg        <= 4'd0;
            pc_reg        <= 32'd0;
            imm_reg       <= 32'd0;
            a_reg         <= 32'd0;
            b_reg         <= 32'd0;
            pc_target_reg <= 32'd0;
            pc_src_reg    <= 1'b0;
            flush_reg     <= 1'b0;
            done_reg      <= 1'b0;
            taken_reg     <= 1'b0;
            bad_reg       <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pc_src_reg <= pc_src_next;
            flush_reg  <= flush_next;
            done_reg   <= done_next;
            taken_reg  <= taken_next;
            bad_reg    <= bad_next;
            if (accept) begin
                bf_reg  <= br_bf;
                pc_reg  <= br_pc;
                imm_reg <= br_imm;
            end
            if (ops_load) begin
                a_reg <= br_src_a;
                b_reg <= br_src_b;
            end
            if (state_reg == EVAL && !kill) begin
                pc_target_reg <= branch_target(pc_reg, imm_reg);
            end
        end
    end

    // kill also masks any pulse already on its way out in the same cycle.
    assign br_ready  = (state_reg == IDLE);
    assign stall     = (state_reg != IDLE);
    assign pc_target = pc_target_reg;
    assign pc_src    = pc_src_reg & ~kill;
    assign flush     = flush_reg & ~kill;
    assign done      = done_reg & ~kill;
    assign taken     = taken_reg & ~kill;
    assign bad_bf    = bad_reg & ~kill;

`ifdef BRANCH_SEQ_STATS_EN
    logic [1:0]  stat_inc;
    logic [15:0] stat_cnt [2];

    assign stat_inc[0] = done & taken;
    assign stat_inc[1] = done & ~taken;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_stat
            logic [15:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg <= 16'd0;
                end else if (stat_inc[gi] && cnt_reg != 16'hFFFF) begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end
            assign stat_cnt[gi] = cnt_reg;
        end
    endgenerate

    assign stat_taken     = stat_cnt[0];
    assign stat_not_taken = stat_cnt[1];
`endif

endmodule

// File: tb/tb_branch_seq.sv
// Directed self-checking bench for branch_seq: latency, outcome per code, target
// arithmetic, and kill/reset aborts in WAIT_OPS and REDIRECT.
module tb_branch_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        br_valid = 1'b0;
    logic [3:0]  br_bf = 4'd0;
    logic [31:0] br_src_a = 32'd0;
    logic [31:0] br_src_b = 32'd0;
    logic [31:0] br_pc = 32'd0;
    logic [31:0] br_imm = 32'd0;
    logic        ops_ready = 1'b0;
    logic        kill = 1'b0;
    logic        br_ready, stall, pc_src, flush, done, taken, bad_bf;
    logic [31:0] pc_target;
`ifdef BRANCH_SEQ_STATS_EN
    logic [15:0] stat_taken, stat_not_taken;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    branch_seq dut (
        .clk            (clk),
        .reset          (reset),
        .br_valid       (br_valid),
        .br_bf          (br_bf),
        .br_src_a       (br_src_a),
        .br_src_b       (br_src_b),
        .br_pc          (br_pc),
        .br_imm         (br_imm),
        .ops_ready      (ops_ready),
        .kill           (kill),
        .br_ready       (br_ready),
        .stall          (stall),
        .pc_src         (pc_src),
        .pc_target      (pc_target),
`ifdef BRANCH_SEQ_STATS_EN
        .stat_taken     (stat_taken),
        .stat_not_taken (stat_not_taken),
`endif
        .flush          (flush),
        .done           (done),
        .taken          (taken),
        .bad_bf         (bad_bf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one branch in the current cycle; returns sampling in the cycle after acceptance.
    task automatic issue(input logic [3:0] bf, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm, input logic ops);
        br_valid  = 1'b1;
        br_bf     = bf;
        br_src_a  = a;
        br_src_b  = b;
        br_pc     = pc;
        br_imm    = imm;
        ops_ready = ops;
        step();
        br_valid  = 1'b0;
    endtask

    task automatic run_branch(input logic [3:0] bf, input logic [31:0] a, input logic [31:0] b,
                              input int idx, input logic exp_t, input logic exp_bad);
        logic [31:0] pc, imm, tgt, tg_seen;
        int          lat;
        logic        tk, bd;
        pc  = 32'h200;
        imm = idx;
        tgt = pc + 32'd4 + (imm << 2);
        tk = 1'bx; bd = 1'bx; tg_seen = 'x;
        issue(bf, a, b, pc, imm, 1'b1);
        // A second offer while busy must be ignored.
        br_valid = 1'b1;
        br_bf    = 4'b0010;
        br_pc    = 32'h500;
        lat = -1;
        for (int c = 1; c <= 6; c++) begin
            if (c == 2) br_valid = 1'b0;
            if (done === 1'b1) begin
                lat = c; tk = taken; bd = bad_bf; tg_seen = pc_target;
                break;
            end
            step();
        end
        br_valid = 1'b0;
        $display("txn bf=%b a=0x%08h b=0x%08h latency=%0d taken=%b bad=%b target=0x%08h",
                 bf, a, b, lat, tk, bd, tg_seen);
        check($sformatf("latency[%0d]", idx), lat, exp_t ? 3 : 2);
        check($sformatf("taken[%0d]", idx), {31'd0, tk}, {31'd0, exp_t});
        check($sformatf("bad_bf[%0d]", idx), {31'd0, bd}, {31'd0, exp_bad});
        check($sformatf("target[%0d]", idx), tg_seen, tgt);
        step();
    endtask

    initial begin
        int stall_cnt, pc_src_cnt, done_at, done_seen;
        logic taken_at_done;
`ifdef BRANCH_SEQ_STATS_EN
        logic [15:0] nt_before;
`endif

        repeat (3) step();
        check("rst_br_ready", br_ready, 1);
        check("rst_stall", stall, 0);
        check("rst_pulses", {pc_src, flush, done, taken, bad_bf}, 0);
        check("rst_pc_target", pc_target, 0);
        reset = 1'b0;
        step();

        // beq taken: 3-cycle latency, single redirect, target 0x110
        issue(4'b1000, 32'd5, 32'd5, 32'h100, 32'd3, 1'b1);
        check("beq_c1_stall", stall, 1);
        check("beq_c1_ready", br_ready, 0);
        step();
        check("beq_c2_done", done, 0);
        check("beq_c2_target", pc_target, 32'h110);
        step();
        $display("txn beq done=%b taken=%b pc_src=%b flush=%b target=0x%08h", done, taken, pc_src, flush, pc_target);
        check("beq_c3_pulses", {pc_src, flush, done, taken}, 4'b1111);
        check("beq_c3_stall", stall, 0);
        step();
        check("beq_c4_pulses", {pc_src, flush, done, taken}, 4'b0000);

        // bltz not-taken with A=0: 2-cycle latency, no flush
        issue(4'b0010, 32'd0, 32'd0, 32'h100, 32'd0, 1'b1);
        check("bltz_c1_done", done, 0);
        step();
        $display("txn bltz done=%b taken=%b flush=%b target=0x%08h", done, taken, flush, pc_target);
        check("bltz_c2_done_taken", {done, taken, flush, pc_src}, 4'b1000);
        check("bltz_c2_target", pc_target, 32'h104);
        step();

        // bgtz with operands late by 4 cycles
        issue(4'b1110, 32'd0, 32'd0, 32'h300, 32'd1, 1'b0);
        stall_cnt = 0; pc_src_cnt = 0; done_at = -1; taken_at_done = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            if (i == 4) begin ops_ready = 1'b1; br_src_a = 32'd1; end
            if (i == 5) begin ops_ready = 1'b0; br_src_a = 32'd0; end
            stall_cnt  += int'(stall);
            pc_src_cnt += int'(pc_src);
            if (done === 1'b1 && done_at < 0) begin done_at = i; taken_at_done = taken; end
            step();
        end
        $display("txn bgtz_wait stall_cycles=%0d redirects=%0d done_at=%0d taken=%b",
                 stall_cnt, pc_src_cnt, done_at, taken_at_done);
        check("bgtz_wait_stall", stall_cnt, 6);
        check("bgtz_wait_redirects", pc_src_cnt, 1);
        check("bgtz_wait_done_at", done_at, 7);
        check("bgtz_wait_taken", taken_at_done, 1);

        // bne wrap-around target
        issue(4'b1010, 32'd1, 32'd2, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1);
        step();
        check("bne_wrap_target", pc_target, 32'hFFFFFFF8);
        step();
        $display("txn bne_wrap done=%b taken=%b target=0x%08h", done, taken, pc_target);
        check("bne_wrap_taken", {done, taken}, 2'b11);
        step();

        // illegal code 0101
`ifdef BRANCH_SEQ_STATS_EN
        nt_before = stat_not_taken;
`endif
        issue(4'b0101, 32'd0, 32'd0, 32'h100, 32'd0, 1'b1);
        step();
        $display("txn illegal done=%b bad_bf=%b taken=%b", done, bad_bf, taken);
        check("illegal_flags", {done, bad_bf, taken}, 3'b110);
        step();
`ifdef BRANCH_SEQ_STATS_EN
        check("stat_not_taken_inc", stat_not_taken, nt_before + 16'd1);
`endif

        // Outcome table: code, A, B, expected taken, expected illegal
        run_branch(4'b0010, 32'hFFFFFFFF, 32'd0, 1,  1'b1, 1'b0);
        run_branch(4'b0010, 32'd0,        32'd0, 2,  1'b0, 1'b0);
        run_branch(4'b0011, 32'd0,        32'd0, 3,  1'b1, 1'b0);
        run_branch(4'b0011, 32'hFFFFFFFB, 32'd0, 4,  1'b0, 1'b0);
        run_branch(4'b1001, 32'd7,        32'd8, 5,  1'b0, 1'b0);
        run_branch(4'b1011, 32'd7,        32'd7, 6,  1'b0, 1'b0);
        run_branch(4'b1100, 32'd0,        32'd0, 7,  1'b1, 1'b0);
        run_branch(4'b1101, 32'd1,        32'd0, 8,  1'b0, 1'b0);
        run_branch(4'b1111, 32'd0,        32'd0, 9,  1'b0, 1'b0);
        run_branch(4'b1110, 32'h7FFFFFFF, 32'd0, 10, 1'b1, 1'b0);
        run_branch(4'b0000, 32'd0,        32'd0, 11, 1'b0, 1'b1);
        run_branch(4'b0111, 32'd0,        32'd0, 12, 1'b0, 1'b1);

        // kill in REDIRECT
        issue(4'b1000, 32'd9, 32'd9, 32'h100, 32'd1, 1'b1);
        step();
        kill = 1'b1;
        check("kill_redir_in_redirect", stall, 1);
        step();
        kill = 1'b0;
        $display("txn kill_redirect pc_src=%b done=%b br_ready=%b", pc_src, done, br_ready);
        check("kill_redir_pulses", {pc_src, flush, done, taken}, 4'b0000);
        check("kill_redir_idle", {br_ready, stall}, 2'b10);
        step();

        // reset in REDIRECT
        issue(4'b1000, 32'd9, 32'd9, 32'h100, 32'd1, 1'b1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        $display("txn reset_redirect pc_src=%b done=%b br_ready=%b target=0x%08h", pc_src, done, br_ready, pc_target);
        check("rst_redir_pulses", {pc_src, flush, done, taken}, 4'b0000);
        check("rst_redir_idle", {br_ready, stall}, 2'b10);
        check("rst_redir_target", pc_target, 0);
        step();

        // kill in WAIT_OPS, then late operands must not revive the branch
        issue(4'b1000, 32'd1, 32'd1, 32'h100, 32'd1, 1'b0);
        check("kill_wait_in_wait", stall, 1);
        kill = 1'b1;
        step();
        kill = 1'b0;
        check("kill_wait_idle", {br_ready, stall}, 2'b10);
        ops_ready = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            done_seen += int'(done) + int'(pc_src);
            step();
        end
        $display("txn kill_wait_ops pulses_seen=%0d", done_seen);
        check("kill_wait_no_done", done_seen, 0);

        // reset in WAIT_OPS
        issue(4'b1000, 32'd1, 32'd1, 32'h100, 32'd1, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        $display("txn reset_wait_ops br_ready=%b stall=%b", br_ready, stall);
        check("rst_wait_idle", {br_ready, stall}, 2'b10);

        // kill coinciding with acceptance discards the branch
        kill = 1'b1;
        issue(4'b1000, 32'd1, 32'd1, 32'h100, 32'd1, 1'b1);
        kill = 1'b0;
        check("kill_accept_idle", {br_ready, stall}, 2'b10);
        step();
        $display("txn kill_accept done=%b pc_src=%b", done, pc_src);
        check("kill_accept_no_done", {done, pc_src}, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
